// File: rtl/fbuf_arbiter_if.sv
// Request/response bundle between the framebuffer clients, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the clients' and RAM's view.
interface fbuf_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
    output disp_data, disp_valid, cpu_ack, cpu_rdata, clr_busy, clr_done,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, clr_start, ram_rdata,
    input  disp_data, disp_valid, cpu_ack, cpu_rdata, clr_busy, clr_done,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fbuf_arbiter.sv
// Single-port framebuffer arbiter: display reads > clear sequencer > CPU port,
// one RAM operation per clock, read data routed back by a read-owner tag.
module fbuf_arbiter #(
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic          clk,
  input  logic          res,
  fbuf_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } cpu_state_t;

  cpu_state_t        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [1:0]        rd_owner;
  logic [DATA_W-1:0] disp_data_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              disp_valid_q;
  logic              cpu_ack_q;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic              clr_wr;
  logic              cpu_gnt;

  // Clear writes only once any CPU op has drained; a pending clr_start beats the CPU.
  assign clr_wr  = clr_busy_q && (state == IDLE) && !bus.disp_req;
  assign cpu_gnt = (state == IDLE) && bus.cpu_req && !bus.disp_req
                   && !clr_busy_q && !bus.clr_start;

  assign bus.disp_data  = disp_data_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.clr_busy   = clr_busy_q;
  assign bus.clr_done   = clr_done_q;

  // Grant mux onto the RAM port
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (bus.disp_req) begin
      bus.ram_addr = bus.disp_addr;
    end else if (clr_wr) begin
      bus.ram_addr  = clr_cnt;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = CLR_VALUE;
    end else if (cpu_gnt) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_we    = bus.cpu_we;
      bus.ram_wdata = bus.cpu_wdata;
    end
    if (!res) begin
      bus.ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      rd_owner     <= '0;
      disp_data_q  <= '0;
      cpu_rdata_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      clr_busy_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      clr_done_q   <= 1'b0;

      // bit0: display read in flight, bit1: CPU read in flight
      rd_owner <= {cpu_gnt && !bus.cpu_we, bus.disp_req};
      if (rd_owner[0]) begin
        disp_data_q  <= bus.ram_rdata;
        disp_valid_q <= 1'b1;
      end
      if (rd_owner[1]) begin
        cpu_rdata_q <= bus.ram_rdata;
      end

      if (!clr_busy_q) begin
        if (bus.clr_start) begin
          clr_busy_q <= 1'b1;
          clr_cnt    <= '0;
        end
      end else if (clr_wr) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
        if (clr_cnt == '1) begin
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b1;
        end
      end

      // CPU transaction FSM; cpu_ack is registered so it coincides with WR_ACK/RD_ACK
      case (state)
        IDLE: begin
          if (cpu_gnt) begin
            state     <= bus.cpu_we ? WR_ACK : RD_WAIT;
            cpu_ack_q <= bus.cpu_we;
          end
        end
        WR_ACK:  state <= IDLE;
        RD_WAIT: begin
          state     <= RD_ACK;
          cpu_ack_q <= 1'b1;
        end
        RD_ACK:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fbuf_arbiter.sv
// Directed bench for fbuf_arbiter: RAM model, reference memory and expectation
// queues for display and CPU read data, checked with immediate assertions.
module tb_fbuf_arbiter;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } disp_exp_t;

  logic              clk = 1'b0;
  logic              res;
  int                cyc = 0;
  int                checks = 0;
  int                failures = 0;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ram_ready = 1'b0;
  disp_exp_t         disp_q [$];
  logic [DATA_W-1:0] cpu_q [$];
  disp_exp_t         mon_e;

  fbuf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fbuf_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_VALUE(16'h0000)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 16'hA000 ^ 16'(i);
  endfunction

  // Synchronous single-port RAM, read-before-write; preloaded on the first edge (under reset)
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= ram[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Display data monitor: every valid pops one expectation, lateness counts as a miss
  always @(negedge clk) begin
    if (bus.disp_valid === 1'b1) begin
      if (disp_q.size() == 0) begin
        chk("disp_spurious", 32'(bus.disp_valid), 32'd0);
      end else begin
        mon_e = disp_q.pop_front();
        chk("disp_data", 32'(bus.disp_data), 32'(mon_e.data));
        chk("disp_latency", 32'(cyc), 32'(mon_e.due));
      end
    end else if (disp_q.size() != 0 && cyc >= disp_q[0].due) begin
      mon_e = disp_q.pop_front();
      chk("disp_missing", 32'(bus.disp_valid), 32'd1);
    end
  end

  task automatic disp_rd(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] exp);
    bus.disp_req  = 1'b1;
    bus.disp_addr = addr;
    disp_q.push_back('{data: exp, due: cyc + 2});
  endtask

  task automatic cpu_op(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int exp_lat,
                        input string tag, output int ack_cyc);
    logic [DATA_W-1:0] exp_rd;
    bit acked;
    int n;
    acked   = 1'b0;
    n       = 0;
    ack_cyc = -1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    if (we) ref_mem[addr] = wdata;
    cpu_q.push_back(ref_mem[addr]);
    while (!acked && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.cpu_ack === 1'b1) begin
        acked   = 1'b1;
        ack_cyc = cyc;
        bus.cpu_req = 1'b0;
      end
    end
    bus.cpu_req = 1'b0;
    exp_rd = cpu_q.pop_front();
    chk({tag, "_ack"}, 32'(acked), 32'd1);
    if (acked && !we) chk({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'(exp_rd));
    if (acked && exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    @(negedge clk);
  endtask

  task automatic run_clear(input bit with_disp, output int busy_cnt, output int n_disp,
                           output int done_cyc);
    bit done;
    int n;
    int i;
    done = 1'b0;
    n = 0;
    i = 0;
    busy_cnt = 0;
    n_disp = 0;
    done_cyc = -1;
    bus.clr_start = 1'b1;
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      bus.clr_start = 1'b0;
      if (!with_disp && n <= 2) begin
        chk("clr_first_we", 32'(bus.ram_we), 32'd1);
        chk("clr_first_addr", 32'(bus.ram_addr), 32'(n - 1));
      end
      bus.disp_req = 1'b0;
      if (bus.clr_done === 1'b1) begin
        done = 1'b1;
        done_cyc = cyc;
        chk("clr_busy_at_done", 32'(bus.clr_busy), 32'd0);
      end else begin
        if (bus.clr_busy === 1'b1) busy_cnt++;
        if (with_disp && bus.clr_busy === 1'b1 && (n % 4) == 0) begin
          disp_rd(i < 25 ? 9'h1FF : ADDR_W'(i % 8), i < 25 ? 16'h5A5A : 16'h0000);
          i++;
          n_disp++;
        end
      end
    end
    chk("clr_done_seen", 32'(done), 32'd1);
    @(negedge clk);
    chk("clr_done_once", 32'(bus.clr_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc;
    int ack_cyc2;
    int busy_cnt;
    int n_disp;
    int done_cyc;
    logic [DATA_W-1:0] exp_w;

    res = 1'b0;
    bus.disp_req = 1'b0;  bus.disp_addr = '0;
    bus.cpu_req = 1'b0;   bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // T1: reset with random inputs
    for (int k = 0; k < 3; k++) begin
      bus.disp_req  = 1'($urandom);
      bus.disp_addr = ADDR_W'($urandom);
      bus.cpu_req   = 1'($urandom);
      bus.cpu_we    = 1'($urandom);
      bus.cpu_addr  = ADDR_W'($urandom);
      bus.cpu_wdata = DATA_W'($urandom);
      bus.clr_start = 1'($urandom);
      @(negedge clk);
      chk("rst_disp_data", 32'(bus.disp_data), 32'd0);
      chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("rst_flags", 32'({bus.disp_valid, bus.cpu_ack, bus.clr_busy, bus.clr_done}), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    end
    bus.disp_req = 1'b0; bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.clr_start = 1'b0;
    res = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bus.disp_valid, bus.cpu_ack, bus.clr_busy, bus.clr_done}), 32'd0);
    end

    // T2: CPU write then read back
    cpu_op(1'b1, 9'h005, 16'h1234, 1, "t2_wr", ack_cyc);
    cpu_op(1'b0, 9'h005, 16'h0000, 2, "t2_rd", ack_cyc);

    // T3: display and CPU read collide; display first, CPU one cycle later
    disp_rd(9'h005, ref_mem[5]);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 9'h006;
    cpu_q.push_back(ref_mem[6]);
    #1;
    chk("t3_disp_addr", 32'(bus.ram_addr), 32'h005);
    chk("t3_disp_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    bus.disp_req = 1'b0;
    #1;
    chk("t3_cpu_addr", 32'(bus.ram_addr), 32'h006);
    @(negedge clk);
    chk("t3_cpu_ack_early", 32'(bus.cpu_ack), 32'd0);
    @(negedge clk);
    exp_w = cpu_q.pop_front();
    chk("t3_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    chk("t3_cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_w));
    bus.cpu_req = 1'b0;
    @(negedge clk);

    // T4: full clear without traffic, then read every word through the display port
    run_clear(1'b0, busy_cnt, n_disp, done_cyc);
    chk("t4_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      disp_rd(ADDR_W'(a), ref_mem[a]);
      @(negedge clk);
      bus.disp_req = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);

    // T5: clear with display every 4th cycle and a CPU write pending
    cpu_op(1'b1, 9'h1FF, 16'h5A5A, 1, "t5_pre1", ack_cyc);
    cpu_op(1'b1, 9'h003, 16'h0333, 1, "t5_pre2", ack_cyc);
    fork
      run_clear(1'b1, busy_cnt, n_disp, done_cyc);
      begin
        repeat (10) @(negedge clk);
        cpu_op(1'b1, 9'h1F0, 16'hBEEF, -1, "t5_wr", ack_cyc2);
      end
    join
    chk("t5_busy_cycles", 32'(busy_cnt), 32'(DEPTH + n_disp));
    chk("t5_ack_after_done", 32'(ack_cyc2), 32'(done_cyc + 1));
    repeat (3) @(negedge clk);
    disp_rd(9'h1F0, ref_mem[9'h1F0]);
    @(negedge clk); bus.disp_req = 1'b0; @(negedge clk);
    disp_rd(9'h1FF, ref_mem[9'h1FF]);
    @(negedge clk); bus.disp_req = 1'b0; @(negedge clk);
    disp_rd(9'h003, ref_mem[9'h003]);
    @(negedge clk); bus.disp_req = 1'b0; @(negedge clk);
    repeat (2) @(negedge clk);
    cpu_op(1'b0, 9'h1F0, 16'h0000, 2, "t5_rd", ack_cyc);

    // T6: reset at clear counter 100, then restart from address 0
    bus.clr_start = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      bus.clr_start = 1'b0;
    end
    chk("t6_addr_at_abort", 32'(bus.ram_addr), 32'd100);
    chk("t6_we_at_abort", 32'(bus.ram_we), 32'd1);
    res = 1'b0;
    @(negedge clk);
    chk("t6_rst_flags", 32'({bus.clr_busy, bus.clr_done}), 32'd0);
    chk("t6_rst_we", 32'(bus.ram_we), 32'd0);
    @(negedge clk);
    res = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t6_no_done", 32'({bus.clr_busy, bus.clr_done}), 32'd0);
    end
    run_clear(1'b0, busy_cnt, n_disp, done_cyc);
    chk("t6_busy_cycles", 32'(busy_cnt), 32'(DEPTH));

    repeat (5) @(negedge clk);
    chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
